// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and constants for the data-memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES : bytes per stored word
//   ADDR_LSB   : first byte-address bit that selects a word
//   addr_err() : flags a misaligned or out-of-range byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  // An address is bad when it is not word aligned or when any bit at or
  // above ADDR_LSB+aw is set (i.e. addr >= WORD_BYTES * 2**aw).
  function automatic logic addr_err(input logic [31:0] a, input int aw);
    logic e;
    e = (a[1:0] != 2'd0);
    for (int i = 0; i < 32; i++) begin
      if (i >= aw + ADDR_LSB) begin
        e = e | a[i];
      end else begin
        e = e;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- synchronous single-port word RAM with per-byte write enable.
//   clk     : clock
//   reset   : async active-high; clears only the read-data register
//   i_re    : read strobe; o_rdata shows the word on the next cycle
//   i_we    : per-byte write enables
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data, 0 in any cycle not following a read
// The storage array itself is never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_re,
  input  logic [WORD_BYTES-1:0]   i_we,
  input  logic [AW-1:0]           i_addr,
  input  logic [8*WORD_BYTES-1:0] i_wdata,
  output logic [8*WORD_BYTES-1:0] o_rdata
);

  logic [8*WORD_BYTES-1:0] r_mem [DEPTH_WORDS];
  logic [8*WORD_BYTES-1:0] r_rdata;

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read register: carries data only for the cycle after a read, else 0,
  // so the responder can drive it straight onto its rdata port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= {(8*WORD_BYTES){1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= {(8*WORD_BYTES){1'b0}};
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- load/store responder in front of a word RAM.
//   clk, reset           : clock, async active-high reset
//   req_valid, req_write : request strobe and store(1)/load(0) select
//   addr, wdata          : byte address and store data
//   byte_en              : store byte enables (only with DMEM_BYTE_EN)
//   req_ready            : high only in IDLE
//   rsp_valid            : one-cycle completion pulse
//   rdata, rsp_err       : load data / error flag, valid with rsp_valid
// Optional feature macro: DMEM_BYTE_EN (adds byte_en; otherwise stores
// write all four bytes).
// A request accepted on edge E is answered with rsp_valid high during the
// cycle after edge E+WAIT_CYCLES, so a consumer samples it on edge
// E+WAIT_CYCLES+1. The RAM access (write, or read into its output
// register) happens on the edge that enters RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       LP_DIRECT   = (WAIT_CYCLES == 0);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [AW-1:0]         r_idx;
  logic [31:0]           r_wdata;
  logic [WORD_BYTES-1:0] r_be;
  logic                  r_err;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;

  logic [WORD_BYTES-1:0] w_in_be;
  logic                  w_in_err;
  logic                  w_go_resp;
  logic                  w_cur_write;
  logic [AW-1:0]         w_cur_idx;
  logic [31:0]           w_cur_wdata;
  logic [WORD_BYTES-1:0] w_cur_be;
  logic                  w_cur_err;
  logic                  w_ram_re;
  logic [WORD_BYTES-1:0] w_ram_we;
  logic [31:0]           w_ram_rdata;

`ifdef DMEM_BYTE_EN
  assign w_in_be = byte_en;
`else
  assign w_in_be = 4'hF;
`endif

  assign w_in_err = addr_err(addr, AW);

  // Select the request that completes on the coming edge: the live inputs
  // when WAIT_CYCLES=0 skips WAIT, otherwise the request captured earlier.
  always_comb begin
    w_go_resp   = 1'b0;
    w_cur_write = 1'b0;
    w_cur_idx   = {AW{1'b0}};
    w_cur_wdata = 32'd0;
    w_cur_be    = 4'd0;
    w_cur_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_go_resp   = req_valid & LP_DIRECT;
        w_cur_write = req_write;
        w_cur_idx   = addr[AW+ADDR_LSB-1:ADDR_LSB];
        w_cur_wdata = wdata;
        w_cur_be    = w_in_be;
        w_cur_err   = w_in_err;
      end
      ST_WAIT: begin
        w_go_resp   = (r_cnt == 4'd0);
        w_cur_write = r_write;
        w_cur_idx   = r_idx;
        w_cur_wdata = r_wdata;
        w_cur_be    = r_be;
        w_cur_err   = r_err;
      end
      default: begin
        w_go_resp = 1'b0;
      end
    endcase
  end

  // RAM strobes: bad addresses never touch the array; reset blocks any
  // access so a discarded store cannot land.
  always_comb begin
    w_ram_re = 1'b0;
    w_ram_we = 4'd0;
    if (w_go_resp && !reset && !w_cur_err) begin
      w_ram_re = ~w_cur_write;
      w_ram_we = w_cur_write ? w_cur_be : 4'd0;
    end else begin
      w_ram_re = 1'b0;
      w_ram_we = 4'd0;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Responder FSM with registered handshake and response flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_idx       <= {AW{1'b0}};
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_go_resp;
      r_rsp_err   <= w_go_resp & w_cur_err;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_idx       <= addr[AW+ADDR_LSB-1:ADDR_LSB];
            r_wdata     <= wdata;
            r_be        <= w_in_be;
            r_err       <= w_in_err;
            r_req_ready <= 1'b0;
            if (LP_DIRECT) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LP_CNT_LOAD;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= 4'd0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rdata     = w_ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed self-checking bench for dmem_responder.
// dut_a: WAIT_CYCLES=1, dut_b: WAIT_CYCLES=0, both DEPTH_WORDS=256.
// Inputs are driven and outputs sampled on the falling clock edge; latency
// is the number of rising edges from acceptance to the edge that samples
// rsp_valid high.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        tgt;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_EN
  logic [3:0]  byte_en;
`endif

  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, b_req_ready;
  logic        a_rsp_valid, b_rsp_valid;
  logic        a_rsp_err, b_rsp_err;
  logic [31:0] a_rdata, b_rdata;
  logic        w_req_ready, w_rsp_valid, w_rsp_err;
  logic [31:0] w_rdata;

  int checks;
  int errors;

  assign a_req_valid = req_valid & ~tgt;
  assign b_req_valid = req_valid & tgt;
  assign w_req_ready = tgt ? b_req_ready : a_req_ready;
  assign w_rsp_valid = tgt ? b_rsp_valid : a_rsp_valid;
  assign w_rsp_err   = tgt ? b_rsp_err   : a_rsp_err;
  assign w_rdata     = tgt ? b_rdata     : a_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_write(req_write),
    .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_EN
    .byte_en(byte_en),
`endif
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rdata(a_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_write(req_write),
    .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_EN
    .byte_en(byte_en),
`endif
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rdata(b_rdata), .rsp_err(b_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request from a falling edge; returns latency (-1 on timeout),
  // response data/error, whether rsp_valid dropped one cycle later and
  // whether req_ready was back then. Ends on a falling edge.
  task automatic do_req(input logic t, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output logic pulse_clr, output logic ready_back);
    int guard;
    lat = -1; rd = 32'hFFFF_FFFF; er = 1'bx; pulse_clr = 1'b0; ready_back = 1'b0;
    tgt = t;
    guard = 0;
    while (w_req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) return;
    req_valid = 1'b1; req_write = w; addr = a; wdata = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (w_rsp_valid !== 1'b1 && lat < 40);
    if (w_rsp_valid !== 1'b1) begin
      lat = -1;
      return;
    end
    rd = w_rdata;
    er = w_rsp_err;
    @(negedge clk);
    pulse_clr  = (w_rsp_valid === 1'b0);
    ready_back = (w_req_ready === 1'b1);
  endtask

  task automatic test_reset();
    tgt = 1'b0;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", a_rsp_valid); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", a_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", a_rsp_err); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_b: got %b exp 1", b_req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er, pc, rb;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, pc, rb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL st_lat: got %0d exp 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL st_rsp: got err=%b rdata=%h exp 0/0", er, rd); end
    checks++; if (pc !== 1'b1 || rb !== 1'b1) begin errors++; $display("FAIL st_pulse: got clr=%b ready=%b exp 1/1", pc, rb); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er, pc, rb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_lat: got %0d exp 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data: got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err: got %b exp 0", er); end
    checks++; if (pc !== 1'b1) begin errors++; $display("FAIL ld_pulse: got %b exp 1", pc); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, pc, rb;
    do_req(1'b0, 1'b1, 32'h0, 32'h11111111, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL e_st0_err: got %b exp 0", er); end
    do_req(1'b0, 1'b0, 32'h12, 32'h0, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL e_mis_ld: got err=%b rdata=%h exp 1/0", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL e_mis_lat: got %0d exp 2", lat); end
    do_req(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL e_oor_st: got %b exp 1", er); end
    do_req(1'b0, 1'b1, 32'h3, 32'h77777777, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL e_mis_st: got %b exp 1", er); end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'h11111111 || er !== 1'b0) begin errors++; $display("FAIL e_reload0: got %h err=%b exp 11111111/0", rd, er); end
    do_req(1'b0, 1'b1, 32'h3FC, 32'h13579BDF, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL e_last_st: got %b exp 0", er); end
    do_req(1'b0, 1'b0, 32'h3FC, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL e_last_ld: got %h exp 13579bdf", rd); end
    do_req(1'b0, 1'b0, 32'h8000_0010, 32'h0, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL e_high_ld: got err=%b rdata=%h exp 1/0", er, rd); end
  endtask

  task automatic test_reset_wait();
    int lat; logic [31:0] rd; logic er, pc, rb;
    do_req(1'b0, 1'b1, 32'h20, 32'h0BADF00D, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rw_pre: got %b exp 0", er); end
    tgt = 1'b0; req_valid = 1'b1; req_write = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b exp 0", a_req_ready); end
    reset = 1'b1;
    #1;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rw_async_ready: got %b exp 1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rdata !== 32'h0) begin
      errors++; $display("FAIL rw_async_out: got v=%b e=%b d=%h exp 0/0/0", a_rsp_valid, a_rsp_err, a_rdata); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rw_old: got %h exp 0badf00d", rd); end
  endtask

  task automatic test_reset_resp();
    int lat; logic [31:0] rd; logic er, pc, rb;
    tgt = 1'b0; req_valid = 1'b1; req_write = 1'b0; addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rr_pre: got v=%b d=%h exp 1/deadbeef", a_rsp_valid, a_rdata); end
    reset = 1'b1;
    #1;
    checks++; if (a_rsp_valid !== 1'b0 || a_rdata !== 32'h0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL rr_async: got v=%b d=%h r=%b exp 0/0/1", a_rsp_valid, a_rdata, a_req_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_mem_kept: got %h exp deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, pc, rb;
    logic [7:0] rdy_vec, rv_vec;
    int acc;
    tgt = 1'b1; req_valid = 1'b1; req_write = 1'b1; addr = 32'h8; wdata = 32'h55AA55AA;
    acc = 0; rdy_vec = 8'h00; rv_vec = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rdy_vec[i] = b_req_ready;
      rv_vec[i]  = b_rsp_valid;
      if (b_req_ready === 1'b1) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_acc: got %0d exp 4", acc); end
    checks++; if (rdy_vec !== 8'h55) begin errors++; $display("FAIL b2b_ready: got %h exp 55", rdy_vec); end
    checks++; if (rv_vec !== 8'hAA) begin errors++; $display("FAIL b2b_valid: got %h exp aa", rv_vec); end
    do_req(1'b1, 1'b0, 32'h8, 32'h0, lat, rd, er, pc, rb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_lat: got %0d exp 1", lat); end
    checks++; if (rd !== 32'h55AA55AA || er !== 1'b0) begin errors++; $display("FAIL b2b_data: got %h err=%b exp 55aa55aa/0", rd, er); end
    tgt = 1'b0;
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_byte_en();
    int lat; logic [31:0] rd; logic er, pc, rb;
    byte_en = 4'hF;
    do_req(1'b0, 1'b1, 32'h0, 32'h0, lat, rd, er, pc, rb);
    byte_en = 4'b0101;
    do_req(1'b0, 1'b1, 32'h0, 32'hAABBCCDD, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_st_err: got %b exp 0", er); end
    byte_en = 4'hF;
    do_req(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'h00BB00DD) begin errors++; $display("FAIL be_ld: got %h exp 00bb00dd", rd); end
    byte_en = 4'h0;
    do_req(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, lat, rd, er, pc, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_zero_err: got %b exp 0", er); end
    byte_en = 4'hF;
    do_req(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er, pc, rb);
    checks++; if (rd !== 32'h00BB00DD) begin errors++; $display("FAIL be_zero_ld: got %h exp 00bb00dd", rd); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; tgt = 1'b0;
    addr = 32'h0; wdata = 32'h0;
`ifdef DMEM_BYTE_EN
    byte_en = 4'hF;
`endif
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_store_load();
    test_errors();
    test_reset_wait();
    test_reset_resp();
    test_back_to_back();
`ifdef DMEM_BYTE_EN
    test_byte_en();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
